// File: rtl/pdm_pkg.sv
// Shared types and default configuration for the PDM microphone receiver.
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRE    = 2'd2,
        HOLDOFF = 2'd3
    } clap_state_t;

    localparam int DEF_CLK_HALF_DIV    = 20;
    localparam int DEF_WINDOW          = 64;
    localparam int DEF_THRESH          = 16;
    localparam int DEF_HOLD_SAMPLES    = 2;
    localparam int DEF_HOLDOFF_SAMPLES = 1000;

    localparam int CNT_W = 16;

endpackage

// File: rtl/pdm_decimator.sv
// Mic clock divider, synchronized PDM capture on mic_clk falling edges and
// ones-count decimation over WINDOW bits.
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int CLK_HALF_DIV = DEF_CLK_HALF_DIV,
    parameter int WINDOW       = DEF_WINDOW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mic_data,
    output logic                     mic_clk,
    output logic [$clog2(WINDOW):0]  sample,
    output logic                     sample_valid
);

    localparam int DW = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;
    localparam int BW = $clog2(WINDOW);
    localparam int SW = BW + 1;

    logic          sync1, sync2;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] acc;
    logic          div_tc, fall, last_bit;

    assign div_tc   = (div_cnt == DW'(CLK_HALF_DIV - 1));
    assign fall     = enable && div_tc && mic_clk;
    assign last_bit = (bit_cnt == BW'(WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= mic_data;
            sync2 <= sync1;
        end
    end

    // The final bit of a window goes straight into sample so the accumulator
    // can restart at zero without dropping it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            mic_clk      <= 1'b0;
            bit_cnt      <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            div_cnt      <= '0;
            mic_clk      <= 1'b0;
            bit_cnt      <= '0;
            acc          <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (div_tc) begin
                div_cnt <= '0;
                mic_clk <= ~mic_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall) begin
                if (last_bit) begin
                    sample       <= acc + SW'(sync2);
                    sample_valid <= 1'b1;
                    acc          <= '0;
                    bit_cnt      <= '0;
                end else begin
                    acc     <= acc + SW'(sync2);
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pdm_mic_receiver.sv
// PDM microphone receiver with optional clap detector (macro PDM_CLAP_DETECT_EN);
// without the macro jump is tied low and only decimated samples are produced.
module pdm_mic_receiver
    import pdm_pkg::*;
#(
    parameter int CLK_HALF_DIV    = DEF_CLK_HALF_DIV,
    parameter int WINDOW          = DEF_WINDOW,
    parameter int THRESH          = DEF_THRESH,
    parameter int HOLD_SAMPLES    = DEF_HOLD_SAMPLES,
    parameter int HOLDOFF_SAMPLES = DEF_HOLDOFF_SAMPLES
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mic_data,
    output logic                     mic_clk,
    output logic [$clog2(WINDOW):0]  sample,
    output logic                     sample_valid,
    output logic                     jump
);

    localparam int SW = $clog2(WINDOW) + 1;

    if (WINDOW < 4 || WINDOW > 256 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("pdm_mic_receiver: WINDOW must be a power of two in 4..256");
    end
    if (THRESH < 1 || THRESH > WINDOW / 2) begin : g_bad_thresh
        $error("pdm_mic_receiver: THRESH must be in 1..WINDOW/2");
    end
    if (HOLD_SAMPLES < 1 || HOLDOFF_SAMPLES < 1 || HOLDOFF_SAMPLES > 65535) begin : g_bad_hold
        $error("pdm_mic_receiver: HOLD_SAMPLES >= 1, HOLDOFF_SAMPLES in 1..65535");
    end

    pdm_decimator #(
        .CLK_HALF_DIV (CLK_HALF_DIV),
        .WINDOW       (WINDOW)
    ) u_decimator (
        .clk          (CLK100MHZ),
        .rst          (reset),
        .enable       (enable),
        .mic_data     (mic_data),
        .mic_clk      (mic_clk),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

`ifdef PDM_CLAP_DETECT_EN
    localparam logic [SW-1:0] HALF = SW'(WINDOW / 2);

    clap_state_t      state, state_nx;
    logic [CNT_W-1:0] loud_cnt, loud_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic [SW-1:0]    amp;
    logic             loud;

    // Subtract in whichever order stays non-negative; SW bits cover 0..WINDOW.
    assign amp  = (sample >= HALF) ? (sample - HALF) : (HALF - sample);
    assign loud = (int'(amp) >= THRESH);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            loud_cnt <= '0;
            hold_cnt <= '0;
        end else if (!enable) begin
            state    <= IDLE;
            loud_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            loud_cnt <= loud_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        loud_nx  = loud_cnt;
        hold_nx  = hold_cnt;
        jump     = enable && (state == FIRE);
        case (state)
            IDLE: begin
                if (sample_valid && loud) begin
                    state_nx = (HOLD_SAMPLES <= 1) ? FIRE : ARMED;
                    loud_nx  = (HOLD_SAMPLES <= 1) ? '0 : CNT_W'(1);
                end
            end
            ARMED: begin
                if (sample_valid) begin
                    if (!loud) begin
                        state_nx = IDLE;
                        loud_nx  = '0;
                    end else if (int'(loud_cnt) + 1 >= HOLD_SAMPLES) begin
                        state_nx = FIRE;
                        loud_nx  = '0;
                    end else begin
                        loud_nx = loud_cnt + 1'b1;
                    end
                end
            end
            FIRE: begin
                state_nx = HOLDOFF;
                hold_nx  = '0;
            end
            HOLDOFF: begin
                if (sample_valid) begin
                    if (int'(hold_cnt) + 1 >= HOLDOFF_SAMPLES) begin
                        state_nx = IDLE;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
`else
    assign jump = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Directed bench for pdm_mic_receiver (CLK_HALF_DIV=2, WINDOW=8, THRESH=3,
// HOLD_SAMPLES=2, HOLDOFF_SAMPLES=4); jump expectations follow PDM_CLAP_DETECT_EN.
module tb_pdm_mic_receiver;

`ifdef PDM_CLAP_DETECT_EN
    localparam logic CLAP = 1'b1;
`else
    localparam logic CLAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, mic_data;
    logic       mic_clk, sample_valid, jump;
    logic [3:0] sample;

    int n_checks = 0;
    int n_fail   = 0;
    int stray    = 0;
    int mode     = 2;   // 0: const 0, 1: const 1, 2: toggle on every mic_clk fall
    logic prev_mc = 1'b0;

    pdm_mic_receiver #(
        .CLK_HALF_DIV    (2),
        .WINDOW          (8),
        .THRESH          (3),
        .HOLD_SAMPLES    (2),
        .HOLDOFF_SAMPLES (4)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .enable       (enable),
        .mic_data     (mic_data),
        .mic_clk      (mic_clk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .jump         (jump)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mode == 2) begin
            if (prev_mc && !mic_clk) mic_data = ~mic_data;
        end else begin
            mic_data = (mode == 1);
        end
        prev_mc = mic_clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for the next sample_valid, returns the sample plus jump and
    // sample_valid as seen in the following cycle.
    task automatic get_sample(output logic [3:0] s, output logic j, output logic sv_next);
        int  n   = 0;
        bit  got = 0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (jump) stray++;
            if (sample_valid) got = 1;
        end
        if (!got) check("sample_timeout", 32'd0, 32'd1);
        s = sample;
        @(posedge clk); #1;
        j       = jump;
        sv_next = sample_valid;
    endtask

    task automatic expect_sample(input string tag, input int m, input logic [3:0] exp_s,
                                 input logic exp_j);
        logic [3:0] s;
        logic       j, svn;
        mode = m;
        get_sample(s, j, svn);
        check({tag, "_sample"}, 32'(s), 32'(exp_s));
        check({tag, "_jump"}, 32'(j), 32'(exp_j));
        check({tag, "_valid_width"}, 32'(svn), 32'd0);
        check({tag, "_hold"}, 32'(sample), 32'(exp_s));
    endtask

    initial begin
        int         n;
        logic [7:0] exp_j;
        reset    = 1'b1;
        enable   = 1'b0;
        mic_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mic_clk", 32'(mic_clk), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_jump", 32'(jump), 32'd0);

        // First window: 8 falls at 4 cycles each, valid seen after edge 32.
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        n = 0;
        while (!sample_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_latency", 32'(n), 32'd32);
        check("first_sample_alt", 32'(sample), 32'd4);
        @(posedge clk); #1;
        check("first_valid_width", 32'(sample_valid), 32'd0);

        n = 0;
        while (!(mic_clk === 1'b0) && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (!(mic_clk === 1'b1) && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (mic_clk !== 1'b0 && n < 20);
        check("mic_clk_high_cycles", 32'(n), 32'd2);
        do begin @(posedge clk); #1; n++; end while (mic_clk !== 1'b1 && n < 20);
        check("mic_clk_period", 32'(n), 32'd4);

        expect_sample("alt", 2, 4'd4, 1'b0);

        // Loud run: fire on 2nd, holdoff eats 4, fire again on the next pair.
        exp_j = 8'b1000_0010;
        for (int i = 0; i < 8; i++)
            expect_sample($sformatf("loud%0d", i), 1, 4'd8, CLAP & exp_j[i]);
        for (int i = 0; i < 4; i++)
            expect_sample($sformatf("clear%0d", i), 2, 4'd4, 1'b0);

        expect_sample("zero0", 0, 4'd0, 1'b0);
        expect_sample("zero1", 0, 4'd0, CLAP);
        for (int i = 0; i < 4; i++)
            expect_sample($sformatf("clear_b%0d", i), 2, 4'd4, 1'b0);

        // 8, 4, 8, 4: the quiet sample drops ARMED each time.
        expect_sample("lql0", 1, 4'd8, 1'b0);
        expect_sample("lql1", 2, 4'd4, 1'b0);
        expect_sample("lql2", 1, 4'd8, 1'b0);
        expect_sample("lql3", 2, 4'd4, 1'b0);

        // Enable drop mid-window.
        repeat (10) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("dis_mic_clk", 32'(mic_clk), 32'd0);
        check("dis_valid", 32'(sample_valid), 32'd0);
        check("dis_jump", 32'(jump), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("dis_sample_held", 32'(sample), 32'd4);
        check("dis_mic_clk_late", 32'(mic_clk), 32'd0);
        @(negedge clk);
        mode   = 1;
        enable = 1'b1;
        expect_sample("reen", 1, 4'd8, 1'b0);

        // Asynchronous reset mid-window.
        mode = 2;
        repeat (12) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sample", 32'(sample), 32'd0);
        check("mid_rst_mic_clk", 32'(mic_clk), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_jump", 32'(jump), 32'd0);
        @(negedge clk);
        mode  = 1;
        reset = 1'b0;
        n = 0;
        while (!sample_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("post_rst_latency", 32'(n), 32'd32);
        check("post_rst_sample", 32'(sample), 32'd8);

        check("stray_jumps", 32'(stray), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
